top_spi_regs: RTL and testbench



---
 rtl/top_spi_regs.sv | 84 ++++++++
 tb/tb_top_spi_regs.sv | 138 +++++++++++++
 2 files changed

// File: rtl/top_spi_regs.sv
// SPI mode-0 slave exposing a 128 x 8 register file to an external master.
// Frame: {RW, ADDR[6:0], DATA[7:0]} MSB first; sclk is the only clock.
module top_spi_regs #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic ss_n,
  input  logic mosi,
  output logic miso
);

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int DEPTH     = 2 ** ADDR_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_DONE      = CNT_W'(FRAME_LEN);

  logic [DATA_W-1:0] regfile [0:DEPTH-1];

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-2:0] rx;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] tx;

  logic [ADDR_W-1:0] addr_now;
  logic              write_now;
  logic              data_phase;

  // Address completes with the bit sampled on this very edge.
  assign addr_now   = {rx[ADDR_W-2:0], mosi};
  assign write_now  = !ss_n && rw_q && (cnt == CNT_DATA_LAST);
  assign data_phase = (cnt > CNT_ADDR_LAST) && (cnt < CNT_DONE);

  // Frame state; a high ss_n asynchronously drops any partial frame.
  always_ff @(posedge sclk or negedge rst_n or posedge ss_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      rx     <= '0;
      addr_q <= '0;
      rw_q   <= 1'b0;
      tx     <= '0;
    end else if (ss_n) begin
      cnt    <= '0;
      rx     <= '0;
      rw_q   <= 1'b0;
    end else if (cnt < CNT_DONE) begin
      cnt <= cnt + 1'b1;
      rx  <= {rx[DATA_W-3:0], mosi};
      if (cnt == CNT_ADDR_LAST) begin
        addr_q <= addr_now;
        rw_q   <= rx[ADDR_W-1];
        tx     <= regfile[addr_now];
      end
    end
  end

  // Register file survives ss_n; only rst_n clears it.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regfile[i] <= '0;
    end else if (write_now) begin
      regfile[addr_q] <= {rx, mosi};
    end
  end

  // miso walks tx MSB first during the data phase; ~cnt[2:0] == 15 - cnt there.
  always_ff @(negedge sclk or negedge rst_n or posedge ss_n) begin
    if (!rst_n) begin
      miso <= 1'b0;
    end else if (ss_n) begin
      miso <= 1'b0;
    end else if (data_phase) begin
      miso <= tx[~cnt[2:0]];
    end else begin
      miso <= 1'b0;
    end
  end

endmodule

// File: tb/tb_top_spi_regs.sv
// Directed bench for top_spi_regs: table of full frames plus abort/extra-clock/reset sequences.
module tb_top_spi_regs;

  logic sclk;
  logic rst_n;
  logic ss_n;
  logic mosi;
  logic miso;

  int n_checks;
  int n_errors;

  top_spi_regs dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .ss_n  (ss_n),
    .mosi  (mosi),
    .miso  (miso)
  );

  typedef struct {
    logic [15:0] frame;
    logic [15:0] exp_miso;
    logic [6:0]  chk_addr;
    logic [7:0]  exp_reg;
  } vec_t;

  vec_t vecs [7];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Shifts nbits of frame (MSB first), then optionally extra clocks with mosi=1.
  // miso is sampled just before each rising edge, as a mode-0 master would.
  task automatic spi_frame(input logic [15:0] frame, input int nbits, input int n_extra,
                           output logic [15:0] rd_word);
    rd_word = '0;
    ss_n = 1'b0;
    #20;
    for (int i = 0; i < nbits; i++) begin
      mosi = frame[15-i];
      #10;
      rd_word[15-i] = miso;
      sclk = 1'b1;
      #10;
      sclk = 1'b0;
    end
    for (int i = 0; i < n_extra; i++) begin
      mosi = 1'b1;
      #10;
      check16("extra_clk_miso", {15'd0, miso}, 16'd0);
      sclk = 1'b1;
      #10;
      sclk = 1'b0;
    end
    #10;
    ss_n = 1'b1;
    mosi = 1'b0;
    #20;
  endtask

  initial begin
    logic [15:0] word;

    n_checks = 0;
    n_errors = 0;
    sclk  = 1'b0;
    ss_n  = 1'b1;
    mosi  = 1'b0;
    rst_n = 1'b0;
    #50;
    rst_n = 1'b1;
    #20;

    check16("reset_miso", {15'd0, miso}, 16'd0);
    for (int a = 0; a < 128; a++)
      check16($sformatf("reset_reg_%02h", a), {8'd0, dut.regfile[a]}, 16'd0);

    vecs[0] = '{16'h923A, 16'h0000, 7'h12, 8'h3A};
    vecs[1] = '{16'h1200, 16'h003A, 7'h12, 8'h3A};
    vecs[2] = '{16'hFF55, 16'h0000, 7'h7F, 8'h55};
    vecs[3] = '{16'h7F00, 16'h0055, 7'h7F, 8'h55};
    vecs[4] = '{16'h0100, 16'h0000, 7'h01, 8'h00};
    vecs[5] = '{16'h9277, 16'h003A, 7'h12, 8'h77};
    vecs[6] = '{16'h12FF, 16'h0077, 7'h12, 8'h77};

    for (int v = 0; v < 7; v++) begin
      spi_frame(vecs[v].frame, 16, 0, word);
      check16($sformatf("vec%0d_miso", v), word, vecs[v].exp_miso);
      check16($sformatf("vec%0d_reg", v), {8'd0, dut.regfile[vecs[v].chk_addr]},
              {8'd0, vecs[v].exp_reg});
    end

    // Abort a write after 10 bits: no write, next frame starts clean.
    spi_frame(16'h8AC3, 10, 0, word);
    check16("abort_reg", {8'd0, dut.regfile[7'h0A]}, 16'h0000);
    spi_frame(16'h0A00, 16, 0, word);
    check16("abort_readback", word, 16'h0000);

    // Extra clocks after a full write are ignored.
    spi_frame(16'h8511, 16, 4, word);
    check16("extra_reg", {8'd0, dut.regfile[7'h05]}, 16'h0011);
    spi_frame(16'h0500, 16, 0, word);
    check16("extra_readback", word, 16'h0011);

    // Reset mid-frame clears everything, including previously written registers.
    ss_n = 1'b0;
    #20;
    for (int i = 0; i < 12; i++) begin
      mosi = (16'h9455 >> (15 - i)) & 1'b1;
      #10;
      sclk = 1'b1;
      #10;
      sclk = 1'b0;
    end
    rst_n = 1'b0;
    #50;
    check16("midrst_miso", {15'd0, miso}, 16'd0);
    ss_n = 1'b1;
    rst_n = 1'b1;
    #20;
    check16("midrst_reg12", {8'd0, dut.regfile[7'h12]}, 16'h0000);
    check16("midrst_reg7f", {8'd0, dut.regfile[7'h7F]}, 16'h0000);
    spi_frame(16'h0500, 16, 0, word);
    check16("midrst_readback", word, 16'h0000);
    spi_frame(16'h9499, 16, 0, word);
    check16("post_rst_write", {8'd0, dut.regfile[7'h14]}, 16'h0099);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
